// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// ALU operations and datapath mux selects. Honours `BRANCH_EXT_EN (blt/bge/bltu/bgeu).
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
    ALU_SRL  = 4'b1000, ALU_SRA = 4'b1001
  } alu_ctrl_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // RES_ALURESULT also feeds the PC; the datapath clears bit 0 there for jalr.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  function automatic logic branchLegal(input logic [2:0] funct3);
    logic w_ok;
`ifdef BRANCH_EXT_EN
    w_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
    w_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
`endif
    return w_ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU operation and an
// illegal-instruction flag. Branch legality depends on `BRANCH_EXT_EN.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_aluCtrl,
  output logic       o_illegal
);

  // funct7[5] only means sub for R-type; for I-type it is an immediate bit except on shifts.
  always_comb begin
    o_aluCtrl = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE, OP_ITYPE: begin
        case (i_funct3)
          3'b000: o_aluCtrl = (i_opcode == OP_RTYPE && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            o_aluCtrl = ALU_SLL;
            o_illegal = i_funct7b5;
          end
          3'b010: o_aluCtrl = ALU_SLT;
          3'b011: o_aluCtrl = ALU_SLTU;
          3'b100: o_aluCtrl = ALU_XOR;
          3'b101: o_aluCtrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: o_aluCtrl = ALU_OR;
          default: o_aluCtrl = ALU_AND;
        endcase
        if (i_opcode == OP_RTYPE && i_funct7b5 && i_funct3 != 3'b000 && i_funct3 != 3'b101)
          o_illegal = 1'b1;
      end
      OP_LOAD, OP_STORE: o_illegal = (i_funct3 != 3'b010);
      OP_BRANCH: begin
        o_aluCtrl = ALU_SUB;
        o_illegal = !branchLegal(i_funct3);
      end
      OP_JALR: o_illegal = (i_funct3 != 3'b000);
      OP_JAL, OP_LUI: o_illegal = 1'b0;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/writeback for RV32I subset,
// with retired-instruction counter. `BRANCH_EXT_EN adds blt/bge/bltu/bgeu.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_EQ,
  input  logic                  i_LT,
  input  logic                  i_LTU,
  input  logic                  i_mem_ready,
  output logic                  o_PCWrite,
  output logic                  o_IRWrite,
  output logic                  o_RegWrite,
  output logic                  o_MemWrite,
  output logic                  o_AdrSrc,
  output logic [1:0]            o_ALUSrcA,
  output logic [1:0]            o_ALUSrcB,
  output logic [1:0]            o_ResultSrc,
  output logic [2:0]            o_ImmSrc,
  output logic [3:0]            o_ALUctrl,
  output logic                  o_illegal,
  output logic                  o_retire,
  output logic [CNT_WIDTH-1:0]  o_instret
);

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [3:0]           w_decAluCtrl;
  logic                 w_decIllegal;
  logic                 w_pcWrite, w_irWrite, w_regWrite, w_memWrite, w_illegal, w_retire;
  logic                 w_unusedBits;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_unusedBits = ^{i_instr[DATA_WIDTH-1:31], i_instr[29:15], i_instr[11:7], i_LT, i_LTU};

  alu_decoder u_aluDecoder (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7b5 (i_instr[30]),
    .o_aluCtrl  (w_decAluCtrl),
    .o_illegal  (w_decIllegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_retire)
        r_instret <= r_instret + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_pcWrite   = 1'b0;
    w_irWrite   = 1'b0;
    w_regWrite  = 1'b0;
    w_memWrite  = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    o_AdrSrc    = 1'b0;
    o_ALUSrcA   = SRCA_PC;
    o_ALUSrcB   = SRCB_FOUR;
    o_ResultSrc = RES_ALUOUT;
    o_ImmSrc    = IMM_I;
    o_ALUctrl   = ALU_ADD;
    case (r_state)
      FETCH: begin
        o_ResultSrc = RES_ALURESULT;
        if (i_mem_ready) begin
          w_irWrite   = 1'b1;
          w_pcWrite   = 1'b1;
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        o_ALUSrcA = SRCA_OLDPC;
        o_ALUSrcB = SRCB_IMM;
        o_ImmSrc  = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
        if (w_decIllegal) begin
          w_illegal   = 1'b1;
          w_retire    = 1'b1;
          w_nextState = FETCH;
        end else begin
          case (w_opcode)
            OP_LOAD, OP_STORE: w_nextState = MEMADR;
            OP_RTYPE:          w_nextState = EXECR;
            OP_ITYPE:          w_nextState = EXECI;
            OP_BRANCH:         w_nextState = BRANCH;
            OP_JAL:            w_nextState = JAL;
            OP_JALR:           w_nextState = JALR;
            OP_LUI:            w_nextState = LUI;
            default:           w_nextState = FETCH;
          endcase
        end
      end
      MEMADR: begin
        o_ALUSrcA   = SRCA_RS1;
        o_ALUSrcB   = SRCB_IMM;
        o_ImmSrc    = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
        w_nextState = (w_opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        o_AdrSrc = 1'b1;
        if (i_mem_ready) w_nextState = MEMWB;
      end
      MEMWB: begin
        w_regWrite  = 1'b1;
        o_ResultSrc = RES_DATA;
        w_retire    = 1'b1;
        w_nextState = FETCH;
      end
      MEMWRITE: begin
        o_AdrSrc   = 1'b1;
        w_memWrite = 1'b1;
        if (i_mem_ready) begin
          w_retire    = 1'b1;
          w_nextState = FETCH;
        end
      end
      EXECR, EXECI: begin
        o_ALUSrcA   = SRCA_RS1;
        o_ALUSrcB   = (r_state == EXECR) ? SRCB_RS2 : SRCB_IMM;
        o_ALUctrl   = w_decAluCtrl;
        w_nextState = ALUWB;
      end
      // jal/jalr link value PC+4 is recomputed here since ALUOut holds the target
      ALUWB: begin
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = FETCH;
        if (w_opcode == OP_JAL || w_opcode == OP_JALR) begin
          o_ALUSrcA   = SRCA_OLDPC;
          o_ALUSrcB   = SRCB_FOUR;
          o_ResultSrc = RES_ALURESULT;
        end
      end
      BRANCH: begin
        o_ALUSrcA   = SRCA_RS1;
        o_ALUSrcB   = SRCB_RS2;
        o_ALUctrl   = ALU_SUB;
        o_ImmSrc    = IMM_B;
        w_retire    = 1'b1;
        w_nextState = FETCH;
        case (w_funct3)
          3'b000: w_pcWrite = i_EQ;
          3'b001: w_pcWrite = !i_EQ;
`ifdef BRANCH_EXT_EN
          3'b100: w_pcWrite = i_LT;
          3'b101: w_pcWrite = !i_LT;
          3'b110: w_pcWrite = i_LTU;
          3'b111: w_pcWrite = !i_LTU;
`endif
          default: w_pcWrite = 1'b0;
        endcase
      end
      JAL: begin
        o_ALUSrcA   = SRCA_OLDPC;
        o_ImmSrc    = IMM_J;
        w_pcWrite   = 1'b1;
        w_nextState = ALUWB;
      end
      JALR: begin
        o_ALUSrcA   = SRCA_RS1;
        o_ALUSrcB   = SRCB_IMM;
        o_ResultSrc = RES_ALURESULT;
        w_pcWrite   = 1'b1;
        w_nextState = ALUWB;
      end
      LUI: begin
        o_ImmSrc    = IMM_U;
        o_ResultSrc = RES_IMM;
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = FETCH;
      end
      default: w_nextState = FETCH;
    endcase
  end

  // Reset masks every side effect combinationally so an aborted instruction writes nothing.
  assign o_PCWrite  = w_pcWrite  & ~rst;
  assign o_IRWrite  = w_irWrite  & ~rst;
  assign o_RegWrite = w_regWrite & ~rst;
  assign o_MemWrite = w_memWrite & ~rst;
  assign o_illegal  = w_illegal  & ~rst;
  assign o_retire   = w_retire   & ~rst;
  assign o_instret  = r_instret;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the reduced RISC-V core. It replaces the single-cycle, two-instruction decoder with a state machine that sequences fetch, decode, execute, memory and writeback over shared datapath resources. It decodes the RV32I base subset: R-type ALU, I-type ALU, lw, sw, branches, jal, jalr and lui. It sits between the instruction register and the datapath muxes and enables, and stalls on a memory-ready handshake.

## Interface
- DATA_WIDTH, 32: instruction width.
- CNT_WIDTH, 32: width of the retired-instruction counter.
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- instr  in  DATA_WIDTH  current contents of the instruction register.
- EQ, LT, LTU  in  1 each  ALU compare flags for rs1 vs rs2.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables and the address-mux select (0 = PC, 1 = ALUOut).
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- ALUctrl  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- illegal  out  1  one-cycle pulse when an unsupported opcode or funct is decoded.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- instret  out  CNT_WIDTH  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=PC, ALUSrcB=const 4, ALUctrl=add.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; the state then moves to DECODE. Otherwise the state holds with all enables at 0.
- DECODE:
  - Computes oldPC+imm(B) into ALUOut for branch and jal targets.
  - Transitions by opcode:
    - 0000011 / 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - 0110111 → LUI.
    - Any other opcode → pulse illegal and return to FETCH; this counts as a retire.
- MEMADR computes rs1+imm. It then goes to MEMREAD for a load or MEMWRITE for a store.
- MEMREAD: AdrSrc=1; waits on mem_ready, then moves to MEMWB.
- MEMWB: RegWrite=1 with ResultSrc=data; then returns to FETCH.
- MEMWRITE: AdrSrc=1 and MemWrite=1; the state holds until mem_ready=1, then returns to FETCH.
- EXECR / EXECI:
  - ALUctrl comes from funct3 and funct7[5].
  - funct7[5] selects sub or sra. For EXECI it is honoured only for shifts.
  - Next state is ALUWB, which drives RegWrite=1 with ResultSrc=ALUOut.
- BRANCH:
  - ALUctrl=sub and ResultSrc=ALUOut.
  - PCWrite is asserted only when the branch is taken: beq on EQ, bne on !EQ.
- JAL and JALR:
  - Both write PC+4 to rd.
  - JAL: PC ← ALUOut.
  - JALR: PC ← (rs1+imm) & ~1.
- LUI: RegWrite=1 with ResultSrc=imm(U).
- retire pulses in the last state of each instruction. instret increments on retire and wraps modulo 2^CNT_WIDTH.
- Unsupported funct3 in a branch, load or store pulses illegal and returns to FETCH with no writes.

## Timing
- Reset values:
  - State = FETCH and instret = 0.
  - All enables (PCWrite, IRWrite, RegWrite, MemWrite) are 0 while rst is high.
  - retire = 0 and illegal = 0.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write occurs after rst rises.
- Outputs are combinational from state, instr and flags. The state register and instret are the only flops.
- Cycle counts with mem_ready held at 1:
  - branch and lui: 3.
  - R, I, store, jal and jalr: 4.
  - load: 5.
- Each wait cycle on mem_ready adds exactly one cycle.

## Configuration
- BRANCH_EXT_EN:
  - Defined: BRANCH also decodes blt (LT), bge (!LT), bltu (LTU) and bgeu (!LTU).
  - Undefined: funct3 values 100–111 in branches raise illegal and cause no PC write.

## Structure
- Package ctrl_pkg holds:
  - The state enum.
  - Opcode localparams.
  - The ALUctrl enum.
  - The ImmSrc, ALUSrcA, ALUSrcB and ResultSrc encodings.
- Sub-module alu_decoder is a combinational decode of opcode, funct3 and funct7[5] into ALUctrl and illegal. The FSM and instret stay in the top module.

## Test plan
- Reset, then release: PCWrite and IRWrite are asserted in the first cycle with mem_ready=1; instret=0.
- addi x1,x0,5 (0x00500093) with mem_ready=1: 4 cycles; RegWrite only in ALUWB; ALUctrl=0000; one retire pulse.
- bne x1,x0,-4 (0xFE009EE3): with EQ=0, PCWrite is asserted in BRANCH; with EQ=1, no PCWrite. Either way 3 cycles.
- lw x2,0(x1) (0x0000A103) with mem_ready low for 2 cycles in MEMREAD: 7 cycles total; RegWrite only in MEMWB.
- blt (funct3=100) with LT=1: PCWrite when BRANCH_EXT_EN is defined; illegal pulse and no PCWrite when it is not.
- Opcode 0x7F: illegal pulse, retire increments, no writes. rst asserted in MEMWRITE: MemWrite drops in the same cycle and the state is FETCH after reset.
